// File: rtl/boton_antirrebote_pkg.sv
// Shared FSM encoding and helpers for the push-button debouncer.
// State values match the encodings used by the other debounce stages.
package boton_antirrebote_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAIT1   = 2'b01,
        S_PRESSED = 2'b10,
        S_WAIT0   = 2'b11
    } state_t;

    // The clean level is high once a press has been accepted, until the release is accepted.
    function automatic logic is_level_high(input state_t s);
        return (s == S_PRESSED) || (s == S_WAIT0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; 2-cycle latency.
// No handshake: the output simply follows d two clk edges later.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/boton_antirrebote.sv
// Button debouncer: clean level plus one-cycle press pulse, both registered.
// Level/pulse follow btn_in by 2 + DEBOUNCE_CYCLES edges; no backpressure.
module boton_antirrebote
    import boton_antirrebote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pulse_next;
    logic             level_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt       <= cnt_next;
            btn_level <= level_next;
            btn_pulse <= pulse_next;
        end
    end

    // Input changes are tested before the terminal count, so a change on that cycle rejects.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (btn_sync) begin
                    state_next = S_WAIT1;
                    cnt_next   = '0;
                end
            end
            S_WAIT1: begin
                if (!btn_sync) begin
                    state_next = S_IDLE;
                end else if (cnt == CNT_TERM) begin
                    state_next = S_PRESSED;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!btn_sync) begin
                    state_next = S_WAIT0;
                    cnt_next   = '0;
                end
            end
            S_WAIT0: begin
                if (btn_sync) begin
                    state_next = S_PRESSED;
                end else if (cnt == CNT_TERM) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        level_next = is_level_high(state_next);
    end

endmodule

// File: tb/tb_boton_antirrebote.sv
// Directed bench for the debouncer with a pulse scoreboard keyed by edge number.
module tb_boton_antirrebote;
    import boton_antirrebote_pkg::*;

    localparam int DB = 4;
    localparam int LAT = 2 + DB;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k;
    int exp_q[$];
    logic [2:0] cnt3 = 3'd0;

    boton_antirrebote #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge; then compare any pulse against the scoreboard.
    task automatic step();
        logic exp_now;
        @(posedge clk);
        cyc++;
        #1;
        exp_now = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (btn_pulse === 1'b1 || exp_now) begin
            checks++;
            assert (btn_pulse === exp_now) else begin
                errors++;
                $error("FAIL pulse at edge %0d: observed %b expected %b", cyc, btn_pulse, exp_now);
            end
            if (exp_now) void'(exp_q.pop_front());
        end
        if (btn_pulse === 1'b1) cnt3++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b1;

        // 1. reset dominates a held button
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_level", btn_level, 1'b0);
            check("rst_pulse", btn_pulse, 1'b0);
        end
        rst = 1'b0;
        k = cyc + 1;
        exp_q.push_back(k + LAT);
        run_to(k + LAT - 1);
        check("t1_level_before", btn_level, 1'b0);
        step();
        check("t1_level_rise", btn_level, 1'b1);
        run(3);
        btn_in = 1'b0;
        k = cyc + 1;
        run_to(k + LAT - 1);
        check("t1_level_hold", btn_level, 1'b1);
        step();
        check("t1_level_fall", btn_level, 1'b0);
        run(3);

        // 2. clean press held 20 cycles
        btn_in = 1'b1;
        k = cyc + 1;
        exp_q.push_back(k + LAT);
        run_to(k + LAT - 1);
        check("t2_level_before", btn_level, 1'b0);
        step();
        check("t2_level_rise", btn_level, 1'b1);
        run_to(k + 19);
        check("t2_level_held", btn_level, 1'b1);
        btn_in = 1'b0;
        k = cyc + 1;
        run_to(k + LAT);
        check("t2_level_released", btn_level, 1'b0);
        run(3);

        // 3. press bounce 1,1,1,0 then steady 1
        btn_in = 1'b1;
        k = cyc + 1;
        run(3);
        btn_in = 1'b0;
        run(1);
        btn_in = 1'b1;
        exp_q.push_back(k + 4 + LAT);
        run_to(k + 4 + LAT - 1);
        check("t3_level_before", btn_level, 1'b0);
        step();
        check("t3_level_rise", btn_level, 1'b1);
        run(4);

        // 4. release bounce 0,1,0 then steady 0
        btn_in = 1'b0;
        k = cyc + 1;
        run(1);
        btn_in = 1'b1;
        run(1);
        btn_in = 1'b0;
        run_to(k + 2 + LAT - 1);
        check("t4_level_hold", btn_level, 1'b1);
        step();
        check("t4_level_fall", btn_level, 1'b0);
        run(3);

        // 5. reset two cycles into the press wait
        btn_in = 1'b1;
        k = cyc + 1;
        run_to(k + 4);
        rst    = 1'b1;
        btn_in = 1'b0;
        run(2);
        check("t5_rst_level", btn_level, 1'b0);
        check("t5_rst_pulse", btn_pulse, 1'b0);
        rst = 1'b0;
        run(10);
        check("t5_level", btn_level, 1'b0);
        check("t5_idle", dut.state_reg == S_IDLE, 1'b1);

        // 6. three clean presses into a 3-bit counter
        cnt3 = 3'd0;
        for (int p = 0; p < 3; p++) begin
            btn_in = 1'b1;
            k = cyc + 1;
            exp_q.push_back(k + LAT);
            run(10);
            check("t6_level_pressed", btn_level, 1'b1);
            btn_in = 1'b0;
            run(10);
            check("t6_level_released", btn_level, 1'b0);
        end
        checks++;
        assert (cnt3 === 3'd3) else begin
            errors++;
            $error("FAIL t6_count: observed %0d expected 3", cnt3);
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL missing_pulses: observed %0d outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
